// File: rtl/mp_drive_sync_fifo_if.sv
// Port bundle for mp_drive_sync_fifo: upstream drive/free micropipeline side plus downstream
// valid/ready drain. MP_DRIVE_STALL_CNT_EN adds the stall observation signals.
interface mp_drive_sync_fifo_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_drive;
  logic [DATA_W-1:0] i_data;
  logic              o_free;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              o_full;
`ifdef MP_DRIVE_STALL_CNT_EN
  logic [15:0]       o_stall_cnt;
  logic              o_stall;

  modport slave (
    input  i_drive, i_data, i_ready,
    output o_free, o_valid, o_data, o_full, o_stall_cnt, o_stall
  );
  modport master (
    output i_drive, i_data, i_ready,
    input  o_free, o_valid, o_data, o_full, o_stall_cnt, o_stall
  );
`else
  modport slave (
    input  i_drive, i_data, i_ready,
    output o_free, o_valid, o_data, o_full
  );
  modport master (
    output i_drive, i_data, i_ready,
    input  o_free, o_valid, o_data, o_full
  );
`endif
endinterface

// File: rtl/mp_drive_sync_fifo.sv
// Captures asynchronous micropipeline drive events into a clocked FIFO and returns free pulses.
// Optional macro MP_DRIVE_STALL_CNT_EN adds a saturating stall-cycle counter and stall flag.
module mp_drive_sync_fifo #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  mp_drive_sync_fifo_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StPush, StStall} st_e;

  logic                   evt_tog_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   evt_sync;
  logic                   seen_q;
  logic                   pending;
  logic [PtrW-1:0]        wr_q, rd_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   free_q;
  logic                   push, pop, full, valid;
  st_e                    st;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  // Each drive rise flips the toggle; the clock domain detects the change, not the pulse.
  always_ff @(posedge bus.i_drive or negedge rst) begin
    if (!rst) evt_tog_q <= 1'b0;
    else      evt_tog_q <= ~evt_tog_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_tog_q};
  end

  assign evt_sync = sync_q[SYNC_STAGES-1];
  assign pending  = evt_sync ^ seen_q;
  assign full     = (count_q == CntW'(DEPTH));
  assign valid    = (count_q != '0);
  assign pop      = valid & bus.i_ready;

  always_comb begin
    st   = StIdle;
    push = 1'b0;
    if (pending) begin
      if (!full || pop) st = StPush;
      else              st = StStall;
    end
    // Blocking on free_q keeps free from ever pulsing on two consecutive cycles.
    if (st == StPush && !free_q) push = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      free_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      free_q  <= push;
      if (push) begin
        seen_q <= evt_sync;
        wr_q   <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.i_data;
  end

  assign bus.o_free  = free_q;
  assign bus.o_valid = valid;
  assign bus.o_data  = mem_q[rd_q];
  assign bus.o_full  = full;

`ifdef MP_DRIVE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       stall_cnt_q <= '0;
    else if (st == StStall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_stall     = (st == StStall);
`endif

endmodule

// File: tb/tb_mp_drive_sync_fifo.sv
// Self-checking bench for mp_drive_sync_fifo: queue-based reference model with randomized
// ready and data, directed steps for reset, stall, wrap and simultaneous push/pop.
module tb_mp_drive_sync_fifo;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;

  logic clk;
  logic rst;

  mp_drive_sync_fifo_if #(.DATA_W(32)) bus ();

  mp_drive_sync_fifo #(
    .DATA_W     (32),
    .DEPTH      (D),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words plus one outstanding upstream event.
  logic [31:0] q[$];
  logic [31:0] dut_pops[$];
  bit          ev_pend;
  int          ev_age;
  logic [31:0] ev_data;
  bit          free_exp;
  int          stall_exp;
  int          frees_seen;
  int          passes;
  int          total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    ev_pend   = 1'b0;
    ev_age    = 0;
    free_exp  = 1'b0;
    stall_exp = 0;
  endtask

  task automatic model_edge();
    bit do_pop, elig, do_push;
    if (!rst) return;
    do_pop  = (q.size() != 0) && bus.i_ready;
    elig    = ev_pend && (ev_age >= int'(S));
    do_push = elig && ((q.size() < int'(D)) || do_pop);
    if (elig && q.size() == int'(D) && !do_pop && stall_exp < 65535) stall_exp++;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(ev_data);
      ev_pend = 1'b0;
    end
    free_exp = do_push;
    if (ev_pend) ev_age++;
  endtask

  task automatic check_outputs();
    chk("free", bus.o_free, free_exp);
    chk("valid", bus.o_valid, (q.size() != 0));
    chk("full", bus.o_full, (q.size() == int'(D)));
    if (q.size() != 0) chk("data", bus.o_data, q[0]);
`ifdef MP_DRIVE_STALL_CNT_EN
    chk("stall_cnt", bus.o_stall_cnt, stall_exp);
`endif
  endtask

  // One clock: record DUT handshake, advance model at the edge, check on the falling edge.
  task automatic step();
    if (bus.o_valid === 1'b1 && bus.i_ready) dut_pops.push_back(bus.o_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    bus.i_drive = 1'b0;
    if (bus.o_free === 1'b1) frees_seen++;
    check_outputs();
  endtask

  task automatic send(input logic [31:0] d);
    bus.i_data  = d;
    bus.i_drive = 1'b1;
    ev_pend     = 1'b1;
    ev_age      = 0;
    ev_data     = d;
  endtask

  // Upstream waits for its free before the next event; ready is random or held low.
  task automatic wait_free(input bit rand_ready);
    for (int n = 0; n < 60 && ev_pend; n++) begin
      bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
  endtask

  initial begin
    int f0;
    rst         = 1'b1;
    bus.i_drive = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    passes      = 0;
    total       = 0;
    frees_seen  = 0;
    model_reset();
    #2 rst = 1'b0;

    // Reset held with drive toggling: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_drive = ~bus.i_drive;
      #1;
      chk("rst_free", bus.o_free, 1'b0);
      chk("rst_valid", bus.o_valid, 1'b0);
      chk("rst_full", bus.o_full, 1'b0);
    end
    @(negedge clk);
    bus.i_drive = 1'b0;
    rst = 1'b1;
    repeat (6) step();

    // Single event.
    f0 = frees_seen;
    send(32'hDEADBEEF);
    repeat (S + 3) step();
    chk("single_free_cnt", frees_seen - f0, 1);
    chk("single_data", bus.o_data, 32'hDEADBEEF);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    step();

    // Fill with 5 events: fifth stalls until a pop.
    f0 = frees_seen;
    for (int v = 1; v <= 5; v++) begin
      send(v);
      repeat (S + 2) step();
    end
    repeat (4) step();
    chk("fill_free_cnt", frees_seen - f0, 4);
    chk("fill_full", bus.o_full, 1'b1);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    chk("stall_release_free", bus.o_free, 1'b1);
    chk("stall_release_full", bus.o_full, 1'b1);
    chk("stall_release_head", bus.o_data, 32'd2);
    repeat (2) step();
    bus.i_ready = 1'b1;
    repeat (5) step();
    bus.i_ready = 1'b0;
    step();

    // Wrap and order with random ready.
    dut_pops.delete();
    for (int i = 0; i < 10; i++) begin
      send(32'h10 + i);
      wait_free(1'b1);
    end
    bus.i_ready = 1'b1;
    repeat (8) step();
    bus.i_ready = 1'b0;
    step();
    chk("wrap_count", dut_pops.size(), 10);
    for (int i = 0; i < 10 && i < dut_pops.size(); i++) chk("wrap_order", dut_pops[i], 32'h10 + i);

    // Random data and random ready.
    for (int i = 0; i < 24; i++) begin
      send($urandom);
      wait_free(1'b1);
    end
    bus.i_ready = 1'b1;
    repeat (8) step();
    bus.i_ready = 1'b0;
    step();

    // Reset while full with a stalled event.
    for (int v = 0; v < 5; v++) begin
      send(32'hC0 + v);
      if (v < 4) wait_free(1'b0);
    end
    repeat (S + 3) step();
    chk("pre_rst_full", bus.o_full, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", bus.o_valid, 1'b0);
    chk("midrst_full", bus.o_full, 1'b0);
    chk("midrst_free", bus.o_free, 1'b0);
    step();
    rst = 1'b1;
    f0 = frees_seen;
    repeat (6) step();
    chk("dropped_no_free", frees_seen - f0, 0);
    send(32'hA5A5A5A5);
    wait_free(1'b0);
    step();
    chk("post_rst_data", bus.o_data, 32'hA5A5A5A5);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    step();

    // Push coincides with pop at count==1.
    send(32'h111);
    wait_free(1'b0);
    send(32'h222);
    for (int n = 0; n < 10 && ev_age < int'(S); n++) step();
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    chk("sim_valid", bus.o_valid, 1'b1);
    chk("sim_full", bus.o_full, 1'b0);
    chk("sim_data", bus.o_data, 32'h222);
    chk("sim_free", bus.o_free, 1'b1);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    step();
    chk("final_empty", bus.o_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
